// File: rtl/audio_pkg.sv
// audio_pkg: shared sample types, FSM states and saturation limits for the audio output path.
package audio_pkg;
    localparam int DEF_DATA_W = 24;
    typedef struct packed {
        logic [DEF_DATA_W-1:0] left;
        logic [DEF_DATA_W-1:0] right;
    } stereo_t;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_e;
    localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};
endpackage

// File: rtl/audio_out_buffer_if.sv
// audio_out_buffer_if: filter-side input, CODEC write port and status of the output buffer.
interface audio_out_buffer_if #(
    parameter int DATA_W = audio_pkg::DEF_DATA_W,
    parameter int DEPTH  = 8,
    parameter int UCNT_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    logic              in_valid;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic              in_ready;
    logic              write_ready;
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [UCNT_W-1:0] underrun_cnt;
    modport master (
        output in_valid, in_left, in_right, write_ready,
        input  in_ready, write, writedata_left, writedata_right, level, overflow, underrun_cnt
    );
    modport slave (
        input  in_valid, in_left, in_right, write_ready,
        output in_ready, write, writedata_left, writedata_right, level, overflow, underrun_cnt
    );
endinterface

// File: rtl/stereo_fifo.sv
// stereo_fifo: DEPTH x W synchronous FIFO with occupancy; push when full and pop when empty are ignored.
module stereo_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/audio_out_buffer.sv
// audio_out_buffer: queues stereo pairs and issues spaced CODEC write pulses, tracking overflow/underrun.
// Optional AUD_OUT_SAT_GAIN_EN applies a saturating left shift of GAIN_SHIFT on load.
module audio_out_buffer
    import audio_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = 8,
    parameter int UCNT_W     = 8,
    parameter int GAIN_SHIFT = 1
) (
    input logic          CLOCK_50,
    input logic          reset,
    audio_out_buffer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_GAP   = GAP;
    logic [1:0]          state;
    logic                wr_q, full, empty, pop;
    logic [2*DATA_W-1:0] head;
    logic [DATA_W-1:0]   ld_l, ld_r;
    function automatic logic [DATA_W-1:0] sat_gain(input logic [DATA_W-1:0] x);
        logic [DATA_W+GAIN_SHIFT-1:0] w;
        w = {{GAIN_SHIFT{x[DATA_W-1]}}, x} << GAIN_SHIFT;
        // the dropped high bits must all equal the new sign bit, otherwise clamp
        return (w[DATA_W+GAIN_SHIFT-1:DATA_W-1] == '0 || &w[DATA_W+GAIN_SHIFT-1:DATA_W-1]) ? w[DATA_W-1:0] :
               w[DATA_W+GAIN_SHIFT-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction
`ifdef AUD_OUT_SAT_GAIN_EN
    assign ld_l = sat_gain(head[2*DATA_W-1:DATA_W]);
    assign ld_r = sat_gain(head[DATA_W-1:0]);
`else
    assign ld_l = head[2*DATA_W-1:DATA_W];
    assign ld_r = head[DATA_W-1:0];
`endif
    stereo_fifo #(.W(2*DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(CLOCK_50), .rst(reset), .push(bus.in_valid), .pop(pop),
        .din({bus.in_left, bus.in_right}), .dout(head), .level(bus.level), .full(full), .empty(empty)
    );
    assign bus.in_ready = !full;
    assign pop = state == S_IDLE && bus.write_ready && !empty;
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            wr_q                <= 1'b0;
            bus.write           <= 1'b0;
            bus.writedata_left  <= '0;
            bus.writedata_right <= '0;
            bus.overflow        <= 1'b0;
            bus.underrun_cnt    <= '0;
        end else begin
            wr_q      <= bus.write_ready;
            state     <= pop ? S_ISSUE : state == S_ISSUE ? S_GAP : S_IDLE;
            bus.write <= pop;
            if (bus.in_valid && full) bus.overflow <= 1'b1;
            if (state == S_IDLE && bus.write_ready && !wr_q && empty && !(&bus.underrun_cnt))
                bus.underrun_cnt <= bus.underrun_cnt + UCNT_W'(1);
            if (pop) begin
                bus.writedata_left  <= ld_l;
                bus.writedata_right <= ld_r;
            end
        end
    end
endmodule

// File: tb/tb_audio_out_buffer.sv
// tb_audio_out_buffer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_audio_out_buffer;
    import audio_pkg::*;
    localparam int DW = 24, DEPTH = 8, GS = 1;
    logic CLOCK_50 = 0;
    logic reset = 1;
    always #5 CLOCK_50 = ~CLOCK_50;
    audio_out_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH), .UCNT_W(8)) bus0();
    audio_out_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH), .UCNT_W(3)) bus1();
    audio_out_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .UCNT_W(8), .GAIN_SHIFT(GS)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus0));
    audio_out_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .UCNT_W(3), .GAIN_SHIFT(GS)) dut_small (
        .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus1));
    int vec = 0, err = 0;
    stereo_t q[$];
    bit m_ov, wr_prev, e_write;
    int m_uc, since;
    logic [23:0] e_l, e_r;

    function automatic logic [23:0] g(input logic [23:0] x);
`ifdef AUD_OUT_SAT_GAIN_EN
        longint s;
        s = longint'($signed(x)) * (longint'(1) << GS);
        if (s > longint'(SAT_MAX)) return SAT_MAX;
        if (s < -(longint'(1) << 23)) return SAT_MIN;
        return s[23:0];
`else
        return x;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_uc = 0; since = 3; wr_prev = 0; e_write = 0; e_l = 0; e_r = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        bus0.in_valid = 0; bus0.in_left = 0; bus0.in_right = 0; bus0.write_ready = 0;
        bus1.in_valid = 0; bus1.in_left = 0; bus1.in_right = 0; bus1.write_ready = 0;
        @(posedge CLOCK_50); #1;
        reset = 0;
        model_reset();
    endtask

    // one clock of stimulus; the model advances by the rules: a pair leaves when the CODEC is ready,
    // data is queued and at least 3 cycles have passed since the previous pop
    task automatic drive(input bit v, input logic [23:0] l, input logic [23:0] r, input bit wr);
        bit idle, pop;
        int lvl;
        stereo_t p;
        bus0.in_valid = v; bus0.in_left = l; bus0.in_right = r; bus0.write_ready = wr;
        lvl = q.size();
        idle = since >= 3;
        pop = idle && wr && lvl > 0;
        if (idle && wr && !wr_prev && lvl == 0 && m_uc < 255) m_uc++;
        e_write = pop;
        if (pop) begin
            e_l = g(q[0].left); e_r = g(q[0].right);
            void'(q.pop_front());
            since = 0;
        end
        if (v && lvl == DEPTH) m_ov = 1;
        else if (v) begin p.left = l; p.right = r; q.push_back(p); end
        since++;
        wr_prev = wr;
        @(posedge CLOCK_50); #1;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if ({bus0.write, bus0.overflow, bus0.level, bus0.writedata_left, bus0.writedata_right, bus0.underrun_cnt} !== '0) begin
            err++; $display("FAIL reset_state got w=%0b ov=%0b lvl=%0d l=%h r=%h uc=%0d exp all zero",
                bus0.write, bus0.overflow, bus0.level, bus0.writedata_left, bus0.writedata_right, bus0.underrun_cnt); end
        vec++; if (bus0.in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready got %0b exp 1", bus0.in_ready); end
        vec++; if (bus1.underrun_cnt !== 3'd0) begin err++; $display("FAIL reset_small_ucnt got %0d exp 0", bus1.underrun_cnt); end
    endtask

    task automatic test_burst();
        logic [23:0] tl[3], tr[3];
        int n = 0, last = -10;
        tl = '{24'h000100, 24'h000200, 24'h000300};
        tr = '{24'hFFFF00, 24'h000002, 24'h000003};
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, tl[i], tr[i], 0);
        vec++; if (bus0.level !== 4'd3) begin err++; $display("FAIL burst_level got %0d exp 3", bus0.level); end
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 0, 1);
            if (bus0.write === 1'b1) begin
                vec++; if (n > 2 || bus0.writedata_left !== g(tl[n]) || bus0.writedata_right !== g(tr[n])) begin
                    err++; $display("FAIL burst_data #%0d got %h/%h", n, bus0.writedata_left, bus0.writedata_right); end
                vec++; if (c - last !== (n == 0 ? c + 10 : 3) || (n == 0 && c != 0)) begin
                    err++; $display("FAIL burst_spacing #%0d at cycle %0d prev %0d", n, c, last); end
                n++; last = c;
            end
        end
        vec++; if (n !== 3) begin err++; $display("FAIL burst_count got %0d exp 3", n); end
        vec++; if (bus0.level !== 4'd0) begin err++; $display("FAIL burst_final_level got %0d exp 0", bus0.level); end
    endtask

    task automatic test_overflow();
        int n = 0;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            drive(1, 24'(i << 4), 24'(i * 3), 0);
            if (i == 8) begin
                vec++; if (bus0.in_ready !== 1'b0) begin err++; $display("FAIL ovf_in_ready got %0b exp 0", bus0.in_ready); end
                vec++; if (bus0.overflow !== 1'b0) begin err++; $display("FAIL ovf_early got %0b exp 0", bus0.overflow); end
            end
        end
        vec++; if (bus0.overflow !== 1'b1) begin err++; $display("FAIL ovf_flag got %0b exp 1", bus0.overflow); end
        vec++; if (bus0.level !== 4'd8) begin err++; $display("FAIL ovf_level got %0d exp 8", bus0.level); end
        for (int c = 0; c < 30; c++) begin
            drive(0, 0, 0, 1);
            if (bus0.write === 1'b1) begin
                vec++; if (bus0.writedata_left !== g(24'((n + 1) << 4)) || bus0.writedata_right !== g(24'((n + 1) * 3))) begin
                    err++; $display("FAIL ovf_drain #%0d got %h/%h", n, bus0.writedata_left, bus0.writedata_right); end
                n++;
            end
        end
        vec++; if (n !== 8) begin err++; $display("FAIL ovf_drain_count got %0d exp 8", n); end
        vec++; if (bus0.overflow !== 1'b1) begin err++; $display("FAIL ovf_sticky got %0b exp 1", bus0.overflow); end
    endtask

    task automatic test_underrun();
        int nw = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0); nw += int'(bus0.write);
            drive(0, 0, 0, 1); nw += int'(bus0.write);
        end
        vec++; if (bus0.underrun_cnt !== 8'd5) begin err++; $display("FAIL underrun_cnt got %0d exp 5", bus0.underrun_cnt); end
        vec++; if (nw !== 0) begin err++; $display("FAIL underrun_write got %0d pulses exp 0", nw); end
        for (int k = 0; k < 10; k++) begin
            bus1.write_ready = 0; @(posedge CLOCK_50); #1;
            bus1.write_ready = 1; @(posedge CLOCK_50); #1;
            vec++; if (int'(bus1.underrun_cnt) !== (k + 1 > 7 ? 7 : k + 1)) begin
                err++; $display("FAIL underrun_sat toggle %0d got %0d", k + 1, bus1.underrun_cnt); end
        end
        vec++; if (bus1.write !== 1'b0) begin err++; $display("FAIL underrun_sat_write got %0b exp 0", bus1.write); end
        bus1.write_ready = 0;
    endtask

    task automatic test_single_push();
        int nw = 0;
        do_reset();
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 1);
        vec++; if (bus0.underrun_cnt !== 8'd1) begin err++; $display("FAIL single_ucnt got %0d exp 1", bus0.underrun_cnt); end
        drive(1, 24'h123456, 24'h654321, 1);
        vec++; if (bus0.write !== 1'b0) begin err++; $display("FAIL single_early got %0b exp 0", bus0.write); end
        drive(0, 0, 0, 1);
        vec++; if (bus0.write !== 1'b1) begin err++; $display("FAIL single_write got %0b exp 1", bus0.write); end
        vec++; if (bus0.writedata_left !== g(24'h123456) || bus0.writedata_right !== g(24'h654321)) begin
            err++; $display("FAIL single_data got %h/%h", bus0.writedata_left, bus0.writedata_right); end
        for (int k = 0; k < 6; k++) begin drive(0, 0, 0, 1); nw += int'(bus0.write); end
        vec++; if (nw !== 0) begin err++; $display("FAIL single_extra got %0d pulses exp 0", nw); end
        vec++; if (bus0.underrun_cnt !== 8'd1) begin err++; $display("FAIL single_ucnt_hold got %0d exp 1", bus0.underrun_cnt); end
    endtask

    task automatic test_reset_issue();
        do_reset();
        for (int i = 0; i < 9; i++) drive(1, 24'($urandom), 24'($urandom), 0);
        drive(0, 0, 0, 1);
        vec++; if (bus0.write !== 1'b1) begin err++; $display("FAIL rst_issue_pre got %0b exp 1", bus0.write); end
        #2 reset = 1;
        #1;
        vec++; if ({bus0.write, bus0.overflow, bus0.level} !== '0) begin
            err++; $display("FAIL rst_issue_async got w=%0b ov=%0b lvl=%0d exp 0", bus0.write, bus0.overflow, bus0.level); end
        vec++; if ({bus0.writedata_left, bus0.writedata_right} !== '0) begin
            err++; $display("FAIL rst_issue_data got %h/%h exp 0", bus0.writedata_left, bus0.writedata_right); end
        do_reset();
    endtask

`ifdef AUD_OUT_SAT_GAIN_EN
    task automatic test_gain();
        logic [23:0] el[2], er[2];
        int n = 0;
        el = '{24'h7FFFFF, 24'h002000};
        er = '{24'h800000, 24'h002000};
        do_reset();
        drive(1, 24'h500000, 24'hA00000, 0);
        drive(1, 24'h001000, 24'h001000, 0);
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 1);
            if (bus0.write === 1'b1) begin
                vec++; if (n > 1 || bus0.writedata_left !== el[n] || bus0.writedata_right !== er[n]) begin
                    err++; $display("FAIL gain #%0d got %h/%h", n, bus0.writedata_left, bus0.writedata_right); end
                n++;
            end
        end
        vec++; if (n !== 2) begin err++; $display("FAIL gain_count got %0d exp 2", n); end
    endtask
`endif

    task automatic test_random();
        bit v, wr;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            v  = $urandom_range(0, 1) == 1;
            wr = c < 400 ? $urandom_range(0, 4) == 0 : $urandom_range(0, 2) != 0;
            drive(v, 24'($urandom), 24'($urandom), wr);
            vec++; if (bus0.write !== e_write) begin err++; $display("FAIL rand_write c%0d got %0b exp %0b", c, bus0.write, e_write); end
            vec++; if (bus0.writedata_left !== e_l || bus0.writedata_right !== e_r) begin
                err++; $display("FAIL rand_data c%0d got %h/%h exp %h/%h", c, bus0.writedata_left, bus0.writedata_right, e_l, e_r); end
            vec++; if (int'(bus0.level) !== q.size()) begin err++; $display("FAIL rand_level c%0d got %0d exp %0d", c, bus0.level, q.size()); end
            vec++; if (bus0.overflow !== m_ov) begin err++; $display("FAIL rand_ovf c%0d got %0b exp %0b", c, bus0.overflow, m_ov); end
            vec++; if (int'(bus0.underrun_cnt) !== m_uc) begin err++; $display("FAIL rand_ucnt c%0d got %0d exp %0d", c, bus0.underrun_cnt, m_uc); end
            vec++; if (bus0.in_ready !== (q.size() < DEPTH)) begin err++; $display("FAIL rand_in_ready c%0d got %0b", c, bus0.in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_overflow();
        test_underrun();
        test_single_push();
        test_reset_issue();
`ifdef AUD_OUT_SAT_GAIN_EN
        test_gain();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/audio_out_buffer.md
Name: audio_out_buffer

Overview:
- Stereo output stage between the smoothing filters and the audio CODEC write port.
- Accepts filtered left/right sample pairs on a valid strobe and queues them in a FIFO.
- Drains the FIFO to the CODEC with a one-cycle write pulse whenever the CODEC reports write_ready.
- Flags overflow and counts underrun events so DAC starvation is visible.

Parameters:
- DATA_W, 24, sample width per channel in bits, two's complement.
- DEPTH, 8, FIFO depth in stereo pairs; must be a power of 2, minimum 2.
- UCNT_W, 8, underrun counter width.
- GAIN_SHIFT, 1, left-shift applied when AUD_OUT_SAT_GAIN_EN is defined.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  a stereo sample pair is presented this cycle.
- in_left  in  DATA_W  left sample, signed.
- in_right  in  DATA_W  right sample, signed.
- in_ready  out  1  equals !full; combinational from FIFO count.
- write_ready  in  1  CODEC DAC side can accept a pair.
- write  out  1  registered one-cycle write strobe to the CODEC.
- writedata_left  out  DATA_W  registered, held stable between writes.
- writedata_right  out  DATA_W  registered, held stable between writes.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; an input pair was dropped.
- underrun_cnt  out  UCNT_W  saturating count of underrun events.

Behaviour:
- Reset values (asynchronous): write=0, writedata_left/right=0, level=0, overflow=0, underrun_cnt=0, FSM=IDLE, read and write pointers=0.
- Push: when in_valid && !full, store {in_left,in_right} at wptr, advance wptr modulo DEPTH.
- Drop: when in_valid && full, discard the pair and set overflow=1. The pair is dropped even if a pop occurs in the same cycle.
- FSM has three states:
  - IDLE: if write_ready && !empty, load the head pair into the writedata registers, pop (rptr+1), go to ISSUE. Otherwise stay.
  - ISSUE: write=1 for exactly this cycle; go to GAP.
  - GAP: write=0 for one cycle so the CODEC can update write_ready; go to IDLE.
- Latency: from write_ready seen in IDLE to write=1 is 1 cycle. Minimum spacing between write pulses is 3 cycles.
- writedata is stable during the write cycle and holds its value until the next load.
- Simultaneous push and pop in the same cycle with level<DEPTH: both happen and level is unchanged.
- Underrun: a write_ready rising edge (registered previous value 0, current 1) while in IDLE with the FIFO empty increments underrun_cnt. The counter saturates at all-ones. No write is issued and writedata keeps its last value.
- Empty FIFO with write_ready held high: only that one underrun event is counted. The pair is issued as soon as a push lands, via IDLE on the next cycle.
- Pointers wrap modulo DEPTH. full is (level==DEPTH); empty is (level==0).
- reset asserted mid-ISSUE drops write to 0 immediately (asynchronous) and discards all queued pairs.
- Sample arithmetic is pass-through unless the optional feature below is compiled in.

Optional Feature:
- Macro: AUD_OUT_SAT_GAIN_EN.
- Defined: each channel is shifted left by GAIN_SHIFT on load into writedata, with signed saturation to DATA_W. Positive overflow gives 0x7FFFFF; negative overflow gives 0x800000 (for DATA_W=24). This adds no extra latency; the saturation logic is combinational before the load register.
- Undefined: samples pass through unmodified and GAIN_SHIFT is ignored.

Decomposition:
- Shared package audio_pkg holds:
  - the DATA_W default;
  - the stereo pair typedef {left,right};
  - the FSM state enum (IDLE, ISSUE, GAP);
  - SAT_MAX and SAT_MIN constants.
- One sub-module, stereo_fifo: a parameterised DEPTH x 2*DATA_W FIFO with push, pop, level, full and empty. It is reusable on the CODEC read side later.
- FSM, underrun logic and gain/saturation stay in the top module.

Test Plan:
- Push 3 pairs (L=0x000100/R=0xFFFF00, L=0x000200/R=0x000002, L=0x000300/R=0x000003), then hold write_ready=1 → 3 write pulses, each 3 cycles apart, data in order, level returns to 0.
- Push 9 pairs with write_ready=0, DEPTH=8 → in_ready=0 after the 8th pair, 9th pair dropped, overflow=1, level=8; draining returns pairs 1..8 only.
- FIFO empty, write_ready toggled 0→1 five times → underrun_cnt=5, write never asserted; then UCNT_W=3 with 10 toggles → counter holds at 7.
- Push one pair while write_ready is held 1 → write=1 exactly one cycle after the push reaches IDLE, with no second pulse.
- Assert reset during ISSUE → write=0 asynchronously, level=0, overflow=0, writedata=0.
- With AUD_OUT_SAT_GAIN_EN and GAIN_SHIFT=1: input 0x500000 → output 0x7FFFFF; input 0xA00000 → output 0x800000; input 0x001000 → output 0x002000.
